// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of the UART transmit
// byte port between N_REQ byte-stream requesters. The owner keeps the grant
// until it completes a byte flagged last, or until it idles for IDLE_TIMEOUT
// cycles, in which case it is evicted and the eviction is counted in drop_cnt.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_valid,
  input  logic                 uart_ready,
  output logic [N_REQ-1:0]     grant,
  output logic [7:0]           drop_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [PTR_W:0]   N_EXT    = (PTR_W + 1)'(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]       state_r;
  logic [PTR_W-1:0] g_r;
  logic [PTR_W-1:0] ptr_r;
  logic [N_REQ-1:0] grant_r;
  logic [CNT_W-1:0] idle_cnt_r;
  logic [7:0]       drop_cnt_r;

  logic [N_REQ-1:0] rot_s;
  logic [PTR_W-1:0] off_s;
  logic [PTR_W:0]   win_sum_s;
  logic [PTR_W-1:0] win_s;
  logic             last_g_s;
  logic             xfer_s;
  logic             release_s;
  logic             timeout_s;

  // Next index after idx, wrapping at N_REQ (handles non-power-of-two N_REQ).
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
    logic [PTR_W:0] sum;
    sum = {1'b0, idx} + {{PTR_W{1'b0}}, 1'b1};
    if (sum >= N_EXT) begin
      wrap_inc = {PTR_W{1'b0}};
    end else begin
      wrap_inc = sum[PTR_W-1:0];
    end
  endfunction

  // Round-robin winner: rotate valids so ptr is bit 0, take the lowest set bit, un-rotate.
  always_comb begin
    rot_s = N_REQ'({req_valid, req_valid} >> ptr_r);
    off_s = {PTR_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = PTR_W'(i);
      end else begin
        off_s = off_s;
      end
    end
    win_sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    if (win_sum_s >= N_EXT) begin
      win_sum_s = win_sum_s - N_EXT;
    end else begin
      win_sum_s = win_sum_s;
    end
    win_s = win_sum_s[PTR_W-1:0];
  end

  // Owner datapath: mux selected by the registered one-hot grant, so non-owners never reach outputs.
  always_comb begin
    uart_data  = 8'h00;
    uart_valid = 1'b0;
    last_g_s   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_r[i]) begin
        uart_data  = req_data[8*i +: 8];
        uart_valid = req_valid[i];
        last_g_s   = req_last[i];
      end else begin
        uart_data  = uart_data;
        uart_valid = uart_valid;
        last_g_s   = last_g_s;
      end
    end
    req_ready = grant_r & {N_REQ{uart_ready}};
  end

  assign xfer_s    = uart_valid & uart_ready;
  assign release_s = xfer_s & last_g_s;
  // A waiting owner (valid high) never counts as idle, so timeout needs valid low.
  assign timeout_s = (state_r == ST_OWN) & ~uart_valid & (idle_cnt_r == CNT_LAST);

  // Arbitration FSM, idle counter, pointer advance and eviction counter.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      g_r        <= {PTR_W{1'b0}};
      ptr_r      <= {PTR_W{1'b0}};
      grant_r    <= {N_REQ{1'b0}};
      idle_cnt_r <= {CNT_W{1'b0}};
      drop_cnt_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req_valid) begin
            state_r    <= ST_OWN;
            g_r        <= win_s;
            grant_r    <= ONE_HOT0 << win_s;
            idle_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_OWN: begin
          if (release_s || timeout_s) begin
            state_r    <= ST_IDLE;
            grant_r    <= {N_REQ{1'b0}};
            ptr_r      <= wrap_inc(g_r);
            idle_cnt_r <= {CNT_W{1'b0}};
            if (timeout_s && (drop_cnt_r != 8'hFF)) begin
              drop_cnt_r <= drop_cnt_r + 8'd1;
            end
          end else if (uart_valid) begin
            idle_cnt_r <= {CNT_W{1'b0}};
          end else begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          grant_r    <= {N_REQ{1'b0}};
          idle_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign grant    = grant_r;
  assign drop_cnt = drop_cnt_r;

endmodule
